// File: rtl/adbg_bytefifo_ctrl.sv
// adbg_bytefifo_ctrl: arbitrates one producer and one consumer onto a
// single-port 8-deep byte FIFO, with a flush mode and an occupancy IRQ.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   PUSH_REQ/DATA/ACK   producer side; ACK is combinational
//   POP_REQ/ACK         consumer side; ACK is combinational
//   POP_DATA/VALID      registered popped byte and its one-cycle strobe
//   FLUSH/FLUSH_BUSY    discard request / high while discarding
//   FIFO_*              byte FIFO control and status
//   IRQ                 registered occupancy interrupt
//
// Build option: define ADBG_BYTEFIFO_IRQ_EN to enable the IRQ_THRESH
// occupancy interrupt; otherwise IRQ is tied low.
module adbg_bytefifo_ctrl #(
   parameter logic [3:0] IRQ_THRESH = 4'h4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       PUSH_REQ,
   input  logic [7:0] PUSH_DATA,
   output logic       PUSH_ACK,
   input  logic       POP_REQ,
   output logic       POP_ACK,
   output logic [7:0] POP_DATA,
   output logic       POP_VALID,
   input  logic       FLUSH,
   output logic       FLUSH_BUSY,
   output logic [7:0] FIFO_DATA_IN,
   output logic       FIFO_EN,
   output logic       FIFO_PUSH_POPn,
   input  logic [7:0] FIFO_DATA_OUT,
   input  logic [3:0] FIFO_BYTES_AVAIL,
   input  logic [3:0] FIFO_BYTES_FREE,
   output logic       IRQ
);

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   localparam logic LG_POP  = 1'b0;
   localparam logic LG_PUSH = 1'b1;

   state_t     r_state;
   logic       r_last_grant;
   logic [7:0] r_pop_data;
   logic       r_pop_valid;

   logic w_arb;
   logic w_push_ok;
   logic w_pop_ok;
   logic w_tie;
   logic w_grant_push;
   logic w_grant_pop;
   logic w_flush_pop;

   // A sampled FLUSH pre-empts any grant in the same cycle.
   assign w_arb     = (r_state == ST_ARB) & ~RST & ~FLUSH;
   assign w_push_ok = PUSH_REQ & (FIFO_BYTES_FREE != 4'd0);
   assign w_pop_ok  = POP_REQ & (FIFO_BYTES_AVAIL != 4'd0);
   assign w_tie     = w_push_ok & w_pop_ok;

   // On a tie the side that did not win the previous tie is served.
   assign w_grant_push = w_arb & w_push_ok &
                         (~w_pop_ok | (r_last_grant == LG_POP));
   assign w_grant_pop  = w_arb & w_pop_ok &
                         (~w_push_ok | (r_last_grant == LG_PUSH));

   assign w_flush_pop = (r_state == ST_FLUSH) & ~RST &
                        (FIFO_BYTES_AVAIL != 4'd0);

   assign FIFO_EN        = w_grant_push | w_grant_pop | w_flush_pop;
   assign FIFO_PUSH_POPn = ~(w_grant_pop | w_flush_pop);
   assign FIFO_DATA_IN   = PUSH_DATA;
   assign PUSH_ACK       = w_grant_push;
   assign POP_ACK        = w_grant_pop;
   assign POP_DATA       = r_pop_data;
   assign POP_VALID      = r_pop_valid;
   assign FLUSH_BUSY     = (r_state == ST_FLUSH);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state      <= ST_ARB;
         r_last_grant <= LG_POP;
         r_pop_data   <= 8'h00;
         r_pop_valid  <= 1'b0;
      end else begin
         r_pop_valid <= w_grant_pop;
         if (w_grant_pop) begin
            r_pop_data <= FIFO_DATA_OUT;
         end
         unique case (r_state)
            ST_ARB: begin
               if (FLUSH) begin
                  r_state <= ST_FLUSH;
               end else if (w_tie) begin
                  r_last_grant <= w_grant_push ? LG_PUSH : LG_POP;
               end
            end
            ST_FLUSH: begin
               if (FIFO_BYTES_AVAIL == 4'd0) begin
                  r_state <= ST_ARB;
               end
            end
         endcase
      end
   end

`ifdef ADBG_BYTEFIFO_IRQ_EN
   logic r_irq;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= (FIFO_BYTES_AVAIL >= IRQ_THRESH);
      end
   end

   assign IRQ = r_irq;
`else
   // Threshold has no function without the interrupt.
   logic w_unused_thresh;
   assign w_unused_thresh = ^IRQ_THRESH;
   assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_adbg_bytefifo_ctrl.sv
// tb_adbg_bytefifo_ctrl: byte FIFO model plus scoreboard around
// adbg_bytefifo_ctrl; scenario tasks run in sequence.
module tb_adbg_bytefifo_ctrl;

   localparam logic [3:0] THR = 4'h4;

   logic       CLK = 1'b0;
   logic       RST;
   logic       PUSH_REQ;
   logic [7:0] PUSH_DATA;
   logic       PUSH_ACK;
   logic       POP_REQ;
   logic       POP_ACK;
   logic [7:0] POP_DATA;
   logic       POP_VALID;
   logic       FLUSH;
   logic       FLUSH_BUSY;
   logic [7:0] FIFO_DATA_IN;
   logic       FIFO_EN;
   logic       FIFO_PUSH_POPn;
   logic [7:0] FIFO_DATA_OUT;
   logic [3:0] FIFO_BYTES_AVAIL;
   logic [3:0] FIFO_BYTES_FREE;
   logic       IRQ;

   adbg_bytefifo_ctrl #(.IRQ_THRESH(THR)) dut (
      .CLK(CLK),
      .RST(RST),
      .PUSH_REQ(PUSH_REQ),
      .PUSH_DATA(PUSH_DATA),
      .PUSH_ACK(PUSH_ACK),
      .POP_REQ(POP_REQ),
      .POP_ACK(POP_ACK),
      .POP_DATA(POP_DATA),
      .POP_VALID(POP_VALID),
      .FLUSH(FLUSH),
      .FLUSH_BUSY(FLUSH_BUSY),
      .FIFO_DATA_IN(FIFO_DATA_IN),
      .FIFO_EN(FIFO_EN),
      .FIFO_PUSH_POPn(FIFO_PUSH_POPn),
      .FIFO_DATA_OUT(FIFO_DATA_OUT),
      .FIFO_BYTES_AVAIL(FIFO_BYTES_AVAIL),
      .FIFO_BYTES_FREE(FIFO_BYTES_FREE),
      .IRQ(IRQ)
   );

   always #5 CLK = ~CLK;

   // Byte FIFO model, depth 8; contents survive controller reset.
   logic [7:0] fm [8];
   logic [2:0] fwr = 3'd0;
   logic [2:0] frd = 3'd0;
   logic [3:0] fcnt = 4'd0;

   always @(posedge CLK) begin
      if (FIFO_EN === 1'b1) begin
         if (FIFO_PUSH_POPn === 1'b1) begin
            if (fcnt < 4'd8) begin
               fm[fwr] <= FIFO_DATA_IN;
               fwr     <= fwr + 3'd1;
               fcnt    <= fcnt + 4'd1;
            end
         end else if (fcnt != 4'd0) begin
            frd  <= frd + 3'd1;
            fcnt <= fcnt - 4'd1;
         end
      end
   end

   assign FIFO_DATA_OUT    = fm[frd];
   assign FIFO_BYTES_AVAIL = fcnt;
   assign FIFO_BYTES_FREE  = 4'd8 - fcnt;

   int         checks = 0;
   int         errors = 0;
   int         n_valid = 0;
   logic       sampled = 1'b0;
   logic       exp_valid = 1'b0;
   logic       exp_irq = 1'b0;
   logic [7:0] expq [$];
   logic [7:0] popq [$];

   // Falling-edge sample: scoreboard bookkeeping and per-cycle checks.
   task automatic sample();
      logic [7:0] d;
      @(negedge CLK);
      sampled = 1'b1;
      if (RST === 1'b1) begin
         exp_valid = 1'b0;
         exp_irq   = 1'b0;
         return;
      end
      checks++;
      if (POP_VALID !== exp_valid) begin
         errors++;
         $display("FAIL pop_valid got=%b exp=%b t=%0t",
                  POP_VALID, exp_valid, $time);
      end
      if (POP_VALID === 1'b1) begin
         checks++;
         if (popq.size() == 0) begin
            errors++;
            $display("FAIL pop_data_extra got=%h exp=none", POP_DATA);
         end else begin
            d = popq.pop_front();
            n_valid++;
            if (POP_DATA !== d) begin
               errors++;
               $display("FAIL pop_data got=%h exp=%h t=%0t",
                        POP_DATA, d, $time);
            end
         end
      end
      checks++;
      if (IRQ !== exp_irq) begin
         errors++;
         $display("FAIL irq got=%b exp=%b t=%0t", IRQ, exp_irq, $time);
      end
      checks++;
      if ((PUSH_ACK & POP_ACK) !== 1'b0) begin
         errors++;
         $display("FAIL both_ack got=%b%b exp=0", PUSH_ACK, POP_ACK);
      end
      if (PUSH_ACK === 1'b1) begin
         checks++;
         if (FIFO_EN !== 1'b1 || FIFO_PUSH_POPn !== 1'b1 ||
             FIFO_DATA_IN !== PUSH_DATA || FIFO_BYTES_FREE == 4'd0) begin
            errors++;
            $display("FAIL push_op got=%b%b/%h/%0d exp=11/%h/free>0",
                     FIFO_EN, FIFO_PUSH_POPn, FIFO_DATA_IN,
                     FIFO_BYTES_FREE, PUSH_DATA);
         end
         expq.push_back(PUSH_DATA);
      end
      if (POP_ACK === 1'b1) begin
         checks++;
         if (FIFO_EN !== 1'b1 || FIFO_PUSH_POPn !== 1'b0 ||
             FIFO_BYTES_AVAIL == 4'd0) begin
            errors++;
            $display("FAIL pop_op got=%b%b/%0d exp=10/avail>0",
                     FIFO_EN, FIFO_PUSH_POPn, FIFO_BYTES_AVAIL);
         end
         if (expq.size() > 0) popq.push_back(expq.pop_front());
      end
      if (FLUSH_BUSY === 1'b1) begin
         checks++;
         if ((PUSH_ACK | POP_ACK) !== 1'b0) begin
            errors++;
            $display("FAIL flush_ack got=%b%b exp=00", PUSH_ACK, POP_ACK);
         end
         if (FIFO_EN === 1'b1 && FIFO_PUSH_POPn === 1'b0 && expq.size() > 0)
            void'(expq.pop_front());
      end
      exp_valid = POP_ACK;
`ifdef ADBG_BYTEFIFO_IRQ_EN
      exp_irq = (FIFO_BYTES_AVAIL >= THR);
`else
      exp_irq = 1'b0;
`endif
   endtask

   task automatic adv();
      if (!sampled) sample();
      @(posedge CLK);
      #1;
      sampled = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1; FLUSH = 1'b1;
      PUSH_REQ = 1'b1; PUSH_DATA = 8'hAA; POP_REQ = 1'b1;
      adv();
      sample();
      checks++;
      if (FIFO_EN !== 1'b0 || PUSH_ACK !== 1'b0 || POP_ACK !== 1'b0) begin
         errors++;
         $display("FAIL rst_ctrl got=%b%b%b exp=000",
                  FIFO_EN, PUSH_ACK, POP_ACK);
      end
      checks++;
      if (FLUSH_BUSY !== 1'b0 || POP_VALID !== 1'b0 || IRQ !== 1'b0 ||
          POP_DATA !== 8'h00) begin
         errors++;
         $display("FAIL rst_regs got=%b%b%b/%h exp=000/00",
                  FLUSH_BUSY, POP_VALID, IRQ, POP_DATA);
      end
      adv();
      FLUSH = 1'b0; PUSH_REQ = 1'b0; POP_REQ = 1'b0;
      RST = 1'b0;
      sample();
      checks++;
      if (FLUSH_BUSY !== 1'b0 || FIFO_EN !== 1'b0) begin
         errors++;
         $display("FAIL rst_release got=%b%b exp=00", FLUSH_BUSY, FIFO_EN);
      end
      adv();
   endtask

   task automatic push_n(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         PUSH_REQ = 1'b1;
         PUSH_DATA = base + 8'(i);
         sample();
         checks++;
         if (PUSH_ACK !== 1'b1) begin
            errors++;
            $display("FAIL push_ack byte=%h got=%b exp=1", PUSH_DATA, PUSH_ACK);
         end
         adv();
      end
      PUSH_REQ = 1'b0;
   endtask

   task automatic test_fill();
      push_n(8'h10, 8);
      PUSH_REQ = 1'b1; PUSH_DATA = 8'h18;
      for (int i = 0; i < 3; i++) begin
         sample();
         checks++;
         if (PUSH_ACK !== 1'b0 || FIFO_EN !== 1'b0 ||
             FIFO_BYTES_AVAIL !== 4'd8) begin
            errors++;
            $display("FAIL full_hold got=%b%b/%0d exp=00/8",
                     PUSH_ACK, FIFO_EN, FIFO_BYTES_AVAIL);
         end
         adv();
      end
      PUSH_REQ = 1'b0;
   endtask

   task automatic test_drain();
      int v0;
      v0 = n_valid;
      POP_REQ = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sample();
         checks++;
         if (POP_ACK !== 1'b1) begin
            errors++;
            $display("FAIL pop_ack idx=%0d got=%b exp=1", i, POP_ACK);
         end
         adv();
      end
      for (int i = 0; i < 3; i++) begin
         sample();
         checks++;
         if (POP_ACK !== 1'b0 || FIFO_EN !== 1'b0) begin
            errors++;
            $display("FAIL empty_hold got=%b%b exp=00", POP_ACK, FIFO_EN);
         end
         adv();
      end
      POP_REQ = 1'b0;
      checks++;
      if (n_valid - v0 != 8 || POP_DATA !== 8'h17) begin
         errors++;
         $display("FAIL drain got=%0d/%h exp=8/17", n_valid - v0, POP_DATA);
      end
   endtask

   task automatic test_alternate();
      RST = 1'b1;
      adv(); adv();
      RST = 1'b0;
      push_n(8'h20, 4);
      for (int i = 0; i < 8; i++) begin
         PUSH_REQ = 1'b1; POP_REQ = 1'b1;
         PUSH_DATA = 8'h30 + 8'(i);
         sample();
         checks++;
         if (PUSH_ACK !== (i % 2 == 0) || POP_ACK !== (i % 2 == 1)) begin
            errors++;
            $display("FAIL alt idx=%0d got=%b%b exp=%b%b", i,
                     PUSH_ACK, POP_ACK, (i % 2 == 0), (i % 2 == 1));
         end
         adv();
      end
      PUSH_REQ = 1'b0; POP_REQ = 1'b0;
   endtask

   task automatic test_flush();
      int nb, np, na;
      nb = 0; np = 0; na = 0;
      push_n(8'h40, 1);
      PUSH_REQ = 1'b1; PUSH_DATA = 8'h50; FLUSH = 1'b1;
      sample();
      checks++;
      if (PUSH_ACK !== 1'b0 || FIFO_EN !== 1'b0 ||
          FIFO_BYTES_AVAIL !== 4'd5) begin
         errors++;
         $display("FAIL flush_prio got=%b%b/%0d exp=00/5",
                  PUSH_ACK, FIFO_EN, FIFO_BYTES_AVAIL);
      end
      adv();
      FLUSH = 1'b0;
      for (int k = 0; k < 20; k++) begin
         sample();
         if (FLUSH_BUSY !== 1'b1) break;
         nb++;
         if (FIFO_EN === 1'b1 && FIFO_PUSH_POPn === 1'b0) np++;
         if (PUSH_ACK === 1'b1 || POP_ACK === 1'b1) na++;
         adv();
      end
      checks++;
      if (nb != 6 || np != 5 || na != 0) begin
         errors++;
         $display("FAIL flush_seq got=busy%0d/pops%0d/acks%0d exp=6/5/0",
                  nb, np, na);
      end
      checks++;
      if (PUSH_ACK !== 1'b1) begin
         errors++;
         $display("FAIL flush_resume got=%b exp=1", PUSH_ACK);
      end
      adv();
      PUSH_REQ = 1'b0;
   endtask

   task automatic test_reset_mid_flush();
      push_n(8'h51, 2);
      FLUSH = 1'b1;
      adv();
      FLUSH = 1'b0;
      checks++;
      if (FLUSH_BUSY !== 1'b1 || FIFO_EN !== 1'b1 ||
          FIFO_BYTES_AVAIL !== 4'd3) begin
         errors++;
         $display("FAIL midflush_enter got=%b%b/%0d exp=11/3",
                  FLUSH_BUSY, FIFO_EN, FIFO_BYTES_AVAIL);
      end
      RST = 1'b1;
      #1;
      checks++;
      if (FLUSH_BUSY !== 1'b0 || FIFO_EN !== 1'b0 || POP_VALID !== 1'b0 ||
          IRQ !== 1'b0 || POP_DATA !== 8'h00) begin
         errors++;
         $display("FAIL midflush_rst got=%b%b%b%b/%h exp=0000/00",
                  FLUSH_BUSY, FIFO_EN, POP_VALID, IRQ, POP_DATA);
      end
      adv(); adv();
      RST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample();
         checks++;
         if (FLUSH_BUSY !== 1'b0 || FIFO_EN !== 1'b0 ||
             FIFO_BYTES_AVAIL !== 4'd3) begin
            errors++;
            $display("FAIL post_rst_arb got=%b%b/%0d exp=00/3",
                     FLUSH_BUSY, FIFO_EN, FIFO_BYTES_AVAIL);
         end
         adv();
      end
      POP_REQ = 1'b1;
      adv(); adv(); adv();
      POP_REQ = 1'b0;
      adv();
      checks++;
      if (POP_DATA !== 8'h52 || FIFO_BYTES_AVAIL !== 4'd0) begin
         errors++;
         $display("FAIL post_rst_drain got=%h/%0d exp=52/0",
                  POP_DATA, FIFO_BYTES_AVAIL);
      end
   endtask

   task automatic test_irq();
      logic e;
`ifdef ADBG_BYTEFIFO_IRQ_EN
      e = 1'b1;
`else
      e = 1'b0;
`endif
      push_n(8'h60, 4);
      sample();
      checks++;
      if (IRQ !== 1'b0) begin
         errors++;
         $display("FAIL irq_pre got=%b exp=0", IRQ);
      end
      adv();
      sample();
      checks++;
      if (IRQ !== e) begin
         errors++;
         $display("FAIL irq_rise got=%b exp=%b", IRQ, e);
      end
      adv();
      POP_REQ = 1'b1;
      adv();
      POP_REQ = 1'b0;
      sample();
      checks++;
      if (IRQ !== e) begin
         errors++;
         $display("FAIL irq_hold got=%b exp=%b", IRQ, e);
      end
      adv();
      sample();
      checks++;
      if (IRQ !== 1'b0) begin
         errors++;
         $display("FAIL irq_fall got=%b exp=0", IRQ);
      end
      adv();
      POP_REQ = 1'b1;
      adv(); adv(); adv();
      POP_REQ = 1'b0;
      adv(); adv();
   endtask

   initial begin
      RST = 1'b1; FLUSH = 1'b0;
      PUSH_REQ = 1'b0; PUSH_DATA = 8'h00; POP_REQ = 1'b0;
      test_reset();
      test_fill();
      test_drain();
      test_alternate();
      test_flush();
      test_reset_mid_flush();
      test_irq();
      checks++;
      if (expq.size() != 0 || popq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left got=%0d/%0d exp=0/0",
                  expq.size(), popq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/adbg_bytefifo_ctrl.md
ADBG_BYTEFIFO_CTRL -- requirements
Module: adbg_bytefifo_ctrl

Interface
REQ-001 SHALL have parameter IRQ_THRESH, default 4'h4, occupancy threshold for IRQ (legal range 1..8).
REQ-002 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port PUSH_REQ  input  1  producer requests one byte write.
REQ-005 SHALL have port PUSH_DATA  input  8  producer byte.
REQ-006 SHALL have port PUSH_ACK  output  1  combinational; byte accepted this cycle.
REQ-007 SHALL have port POP_REQ  input  1  consumer requests one byte read.
REQ-008 SHALL have port POP_ACK  output  1  combinational; pop granted this cycle.
REQ-009 SHALL have port POP_DATA  output  8  registered popped byte.
REQ-010 SHALL have port POP_VALID  output  1  registered one-cycle strobe qualifying POP_DATA.
REQ-011 SHALL have port FLUSH  input  1  request to discard all FIFO contents.
REQ-012 SHALL have port FLUSH_BUSY  output  1  high while in FLUSH state.
REQ-013 SHALL have port FIFO_DATA_IN  output  8  to byte FIFO data input.
REQ-014 SHALL have port FIFO_EN  output  1  to byte FIFO enable.
REQ-015 SHALL have port FIFO_PUSH_POPn  output  1  to byte FIFO direction (1 push, 0 pop).
REQ-016 SHALL have port FIFO_DATA_OUT  input  8  oldest byte from FIFO (combinational).
REQ-017 SHALL have ports FIFO_BYTES_AVAIL, FIFO_BYTES_FREE  input  4 each  FIFO occupancy, 0..8.
REQ-018 SHALL have port IRQ  output  1  registered occupancy interrupt.

Function
REQ-019 FSM states: ARB, FLUSH; at most one FIFO operation per cycle.
REQ-020 ARB: push eligible = PUSH_REQ & FIFO_BYTES_FREE!=0; pop eligible = POP_REQ & FIFO_BYTES_AVAIL!=0.
REQ-021 ARB, single eligible side: grant it; both eligible: grant side opposite to last_grant register, then update last_grant.
REQ-022 Push grant: FIFO_EN=1, FIFO_PUSH_POPn=1, FIFO_DATA_IN=PUSH_DATA, PUSH_ACK=1, same cycle.
REQ-023 Pop grant: FIFO_EN=1, FIFO_PUSH_POPn=0, POP_ACK=1; FIFO_DATA_OUT captured into POP_DATA, POP_VALID=1 next cycle (latency 1), POP_DATA held otherwise.
REQ-024 No grant: FIFO_EN=0, FIFO_PUSH_POPn=1, FIFO_DATA_IN=PUSH_DATA; no ACK asserted.
REQ-025 Full FIFO (FREE=0): PUSH_REQ not acked; empty (AVAIL=0): POP_REQ not acked; requesters hold REQ until ACK.
REQ-026 ARB->FLUSH when FLUSH=1 sampled; FLUSH has priority over push/pop that cycle (no ACK).
REQ-027 FLUSH: pop each cycle while AVAIL!=0 (FIFO_EN=1, FIFO_PUSH_POPn=0), no ACKs, POP_VALID stays 0; return to ARB the cycle AVAIL==0 is sampled.
REQ-028 FLUSH_BUSY=1 exactly while state is FLUSH; FLUSH with empty FIFO spends one cycle in FLUSH.
REQ-029 last_grant unchanged by flush pops.

Reset
REQ-030 RST asserted, any state: state=ARB, last_grant=pop (push wins first tie), POP_DATA=8'h00, POP_VALID=0, IRQ=0, FLUSH_BUSY=0.
REQ-031 While RST high: FIFO_EN=0, PUSH_ACK=0, POP_ACK=0; reset mid-flush abandons flush.

Configuration
REQ-032 Macro ADBG_BYTEFIFO_IRQ_EN defined: IRQ registered, =1 the cycle after FIFO_BYTES_AVAIL>=IRQ_THRESH sampled, else 0.
REQ-033 Macro undefined: IRQ constant 0, no threshold logic; all other behaviour identical.

Verification
REQ-034 Push 8 bytes 8'h10..8'h17 back-to-back -> 8 PUSH_ACKs, 9th PUSH_REQ held unacked while AVAIL=8.
REQ-035 Pop all 8 -> POP_VALID strobes one cycle after each POP_ACK, POP_DATA 8'h10..8'h17 in order; 9th POP_REQ unacked.
REQ-036 PUSH_REQ and POP_REQ held with AVAIL=4 -> grants alternate push,pop,push,... starting with push after reset.
REQ-037 AVAIL=5, FLUSH pulse with PUSH_REQ high -> FLUSH_BUSY 6 cycles, 5 FIFO pops, no ACK/POP_VALID, then PUSH_ACK.
REQ-038 RST asserted mid-flush with AVAIL=3 -> outputs at reset values immediately, state ARB after release.
REQ-039 With ADBG_BYTEFIFO_IRQ_EN, IRQ_THRESH=4: push 4 bytes -> IRQ rises cycle after AVAIL=4; pop one -> IRQ falls; without macro IRQ stays 0.
